// File: rtl/fan_pwm_ctrl.sv
// rtl/fan_pwm_ctrl.sv - board fan PWM controller with kick-start, slew-limited ramp and watchdog
module fan_pwm_ctrl #(
    parameter int DUTY_W = 8,
    parameter int PRE_W  = 16,
    parameter int WD_W   = 16
) (
    input  logic              axi_aclk,
    input  logic              axi_reset,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_target,
    input  logic [PRE_W-1:0]  prescale,
    input  logic [DUTY_W-1:0] ramp_step,
    input  logic [7:0]        kick_periods,
    input  logic [WD_W-1:0]   wd_limit,
    input  logic              wd_pet,
    output logic              fan_pwm,
    output logic [DUTY_W-1:0] duty_current,
    output logic [1:0]        state,
    output logic              period_strobe,
    output logic              wd_expired
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_KICK = 2'd1;
    localparam logic [1:0] ST_RAMP = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
    localparam logic [DUTY_W-1:0] DUTY_ONE = 1;
    localparam logic [PRE_W-1:0]  PRE_ONE  = 1;
    localparam logic [WD_W-1:0]   WD_ONE   = 1;

    logic [PRE_W-1:0]  pre_cnt;
    logic [DUTY_W-1:0] pwm_cnt;
    logic [DUTY_W-1:0] pwm_cnt_next;
    logic [7:0]        kick_cnt;
    logic [7:0]        kick_next;
    logic [WD_W-1:0]   wd_cnt;
    logic [WD_W-1:0]   wd_cnt_next;
    logic [WD_W-1:0]   wd_inc;
    logic              wd_exp_next;
    logic [1:0]        state_next;
    logic [DUTY_W-1:0] duty_next;
    logic [DUTY_W-1:0] eff;
    logic [DUTY_W-1:0] step_base;
    logic [DUTY_W-1:0] stepped;
    logic              tick;
    logic              boundary;
    logic              kick_done;

    // One slew-limited move from cur toward goal; a zero step means jump straight there.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] goal,
        input logic [DUTY_W-1:0] stp
    );
        logic [DUTY_W-1:0] res;
        if (stp == '0) begin
            res = goal;
        end else if (cur < goal) begin
            res = ((goal - cur) <= stp) ? goal : cur + stp;
        end else begin
            res = ((cur - goal) <= stp) ? goal : cur - stp;
        end
        return res;
    endfunction

    assign tick         = (pre_cnt >= prescale);
    assign boundary     = tick && (pwm_cnt == DUTY_MAX);
    assign pwm_cnt_next = tick ? pwm_cnt + DUTY_ONE : pwm_cnt;
    assign eff          = wd_expired ? DUTY_MAX : duty_target;
    // Leaving IDLE steps from 0, leaving KICK steps from full duty, otherwise from the live duty.
    assign step_base    = (state == ST_IDLE) ? '0 : (state == ST_KICK) ? DUTY_MAX : duty_current;
    assign stepped      = step_toward(step_base, eff, ramp_step);
    assign kick_done    = ({1'b0, kick_cnt} + 9'd1) >= {1'b0, kick_periods};
    assign wd_inc       = (wd_cnt < wd_limit) ? wd_cnt + WD_ONE : wd_cnt;

    // Control state and duty: disable acts every cycle, everything else only at a period boundary.
    always_comb begin
        state_next = state;
        duty_next  = duty_current;
        kick_next  = kick_cnt;
        if (!enable) begin
            state_next = ST_IDLE;
            duty_next  = '0;
            kick_next  = '0;
        end else if (boundary) begin
            case (state)
                ST_IDLE: begin
                    if (kick_periods != 8'd0) begin
                        state_next = ST_KICK;
                        duty_next  = DUTY_MAX;
                        kick_next  = '0;
                    end else begin
                        state_next = ST_RAMP;
                        duty_next  = stepped;
                    end
                end
                ST_KICK: begin
                    if (kick_done) begin
                        state_next = ST_RAMP;
                        duty_next  = stepped;
                        kick_next  = '0;
                    end else begin
                        kick_next = kick_cnt + 8'd1;
                    end
                end
                ST_RAMP: begin
                    duty_next = stepped;
                    if (stepped == eff) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    if (eff != duty_current) begin
                        state_next = ST_RAMP;
                        duty_next  = stepped;
                    end
                end
            endcase
        end
    end

    // Watchdog: counts boundaries up to the limit; a pet beats a coincident boundary.
    always_comb begin
        wd_cnt_next = wd_cnt;
        wd_exp_next = wd_expired;
        if (wd_pet || (wd_limit == '0)) begin
            wd_cnt_next = '0;
            wd_exp_next = 1'b0;
        end else if (boundary) begin
            wd_cnt_next = wd_inc;
            wd_exp_next = wd_expired || (wd_inc >= wd_limit);
        end
    end

    // Free-running prescaler and PWM counter.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_ONE;
            pwm_cnt <= pwm_cnt_next;
        end
    end

    // Registered control state and outputs; fan_pwm is built from next-state values so it never lags.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state         <= ST_IDLE;
            duty_current  <= '0;
            kick_cnt      <= '0;
            wd_cnt        <= '0;
            wd_expired    <= 1'b0;
            fan_pwm       <= 1'b0;
            period_strobe <= 1'b0;
        end else begin
            state         <= state_next;
            duty_current  <= duty_next;
            kick_cnt      <= kick_next;
            wd_cnt        <= wd_cnt_next;
            wd_expired    <= wd_exp_next;
            fan_pwm       <= (pwm_cnt_next < duty_next);
            period_strobe <= boundary;
        end
    end

endmodule
